// File: rtl/uart_pkg.sv
// Shared serializer state encoding and line levels for the UART transmit path.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;
`endif

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_ser.sv
// UART frame serializer: start bit, 8 data bits LSB first, optional parity, stop bits.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit period after DATA.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 87,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       busy,
    output logic       txd
);

    localparam int unsigned CW = $clog2(CLK_PER_BIT);

    tx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data_q;
    logic          last_c;

    assign last_c = (cnt == CW'(CLK_PER_BIT - 1));

    // txd follows the state one cycle later, so every level is a flop output
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            data_q  <= '0;
            busy    <= 1'b0;
            txd     <= LINE_IDLE;
        end else begin
            case (state)
                S_IDLE:   txd <= LINE_IDLE;
                S_START:  txd <= LINE_START;
                S_DATA:   txd <= data_q[bit_idx];
`ifdef UART_TX_PARITY_EN
                S_PARITY: txd <= ^data_q;
`endif
                S_STOP:   txd <= LINE_STOP;
                default:  txd <= LINE_IDLE;
            endcase

            case (state)
                S_IDLE: begin
                    if (load) begin
                        state   <= S_START;
                        data_q  <= load_data;
                        cnt     <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (last_c) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (last_c) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (last_c) begin
                        cnt   <= '0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (last_c) begin
                        cnt <= '0;
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART serializer; pops whenever the serializer is idle.
// Build option: UART_TX_PARITY_EN enables even parity in the serializer.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CLK_PER_BIT = 87,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         tx_busy,
    output logic                         txd
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_c;
    logic          pop_c;
    logic [CW-1:0] count_nxt_c;
    logic [7:0]    head_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push_c = wr_en & ~full;
    assign pop_c  = ~tx_busy & ~empty;
    assign head_c = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        if (push_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    // full/empty are registered alongside count so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count    <= count_nxt_c;
            full     <= (count_nxt_c == CW'(DEPTH));
            empty    <= (count_nxt_c == '0);
            overflow <= wr_en & full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    uart_tx_ser #(
        .CLK_PER_BIT (CLK_PER_BIT),
        .STOP_BITS   (STOP_BITS)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (pop_c),
        .load_data (head_c),
        .busy      (tx_busy),
        .txd       (txd)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DEPTH=4, CLK_PER_BIT=4, STOP_BITS=1.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;
    localparam int SB    = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = CPB * (1 + 8 + PAR + SB);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_busy, txd;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .CLK_PER_BIT (CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_busy  (tx_busy),
        .txd      (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Expected line level for a lone frame whose write lands on edge 0
    function automatic logic exp_line(input int k, input logic [7:0] b);
        if (k < 2) return 1'b1;
        if (k < 2 + CPB) return 1'b0;
        if (k < 2 + 9 * CPB) return b[(k - 2 - CPB) / CPB];
        if (PAR != 0 && k < 2 + 10 * CPB) return ^b;
        return 1'b1;
    endfunction

    task automatic rx_frame(output logic [7:0] b, output logic par);
        int n = 0;
        b = 8'h00;
        par = 1'b0;
        while (txd !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check("rx_start_seen", 32'(n < 2000), 1);
        if (n >= 2000) return;
        repeat (CPB / 2) tick();
        check("rx_start_mid", txd, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            b[i] = txd;
        end
        if (PAR != 0) begin
            repeat (CPB) tick();
            par = txd;
        end
        repeat (CPB) tick();
        check("rx_stop", txd, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((tx_busy || !empty) && n < 2000) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(n < 2000), 1);
    endtask

    logic       txd_log  [0:63];
    logic       busy_log [0:63];
    logic [7:0] rb;
    logic       rp;
    int         lows;

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        // single byte 0xA5, cycle-exact line trace
        write_byte(8'hA5);
        txd_log[0]  = txd;
        busy_log[0] = tx_busy;
        check("a5_count0", count, 1);
        for (int k = 1; k <= FRAME + 3; k++) begin
            tick();
            txd_log[k]  = txd;
            busy_log[k] = tx_busy;
        end
        for (int k = 0; k <= FRAME + 3; k++) begin
            check($sformatf("a5_txd_c%0d", k), txd_log[k], exp_line(k, 8'hA5));
        end
        check("a5_busy_c0", busy_log[0], 0);
        check("a5_busy_c1", busy_log[1], 1);
        check("a5_busy_last_stop", busy_log[FRAME], 1);
        check("a5_busy_after", busy_log[FRAME + 2], 0);
        wait_idle();
        repeat (2) tick();

        // fill and overflow: 0x01..0x06 back to back
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(i);
                    tick();
                    if (i == 5) begin
                        check("fill_full", full, 1);
                        check("fill_count", count, 4);
                        check("fill_no_ovf", overflow, 0);
                    end
                    if (i == 6) begin
                        check("fill_ovf", overflow, 1);
                        check("fill_count_drop", count, 4);
                    end
                end
                wr_en = 1'b0;
                tick();
                check("fill_ovf_pulse_end", overflow, 0);
            end
            begin
                logic [7:0] fb;
                logic       fp;
                for (int f = 0; f < 5; f++) begin
                    rx_frame(fb, fp);
                    check($sformatf("fill_byte%0d", f), fb, 32'(f + 1));
                end
            end
        join
        wait_idle();
        repeat (3 * FRAME) tick();
        check("fill_no_sixth_txd", txd, 1);
        check("fill_no_sixth_busy", tx_busy, 0);

        // wrap-around: ten single bytes spaced by a frame
        for (int i = 0; i < 10; i++) begin
            write_byte(8'h10 + 8'(i));
            check("wrap_count", count, 1);
            rx_frame(rb, rp);
            check($sformatf("wrap_byte%0d", i), rb, 32'(8'h10 + 8'(i)));
            wait_idle();
        end
        repeat (2) tick();

        // simultaneous write and pop with count=2
        write_byte(8'h21);
        wr_en = 1'b1;
        wr_data = 8'h22;
        tick();
        wr_data = 8'h23;
        tick();
        wr_en = 1'b0;
        check("sim_count_setup", count, 2);
        repeat (FRAME - 1) tick();
        check("sim_count_pre", count, 2);
        check("sim_idle_gap", tx_busy, 0);
        wr_en = 1'b1;
        wr_data = 8'h24;
        tick();
        wr_en = 1'b0;
        check("sim_count", count, 2);
        check("sim_no_ovf", overflow, 0);
        check("sim_busy", tx_busy, 1);
        for (int f = 0; f < 3; f++) begin
            rx_frame(rb, rp);
            check($sformatf("sim_byte%0d", f), rb, 32'(8'h22 + 8'(f)));
        end
        wait_idle();
        repeat (2) tick();

        // reset during data bit 3 with two bytes queued; write during reset ignored
        write_byte(8'h31);
        wr_en = 1'b1;
        wr_data = 8'h32;
        tick();
        wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        check("mrst_count", count, 2);
        repeat (16) tick();
        rst = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        check("mrst_txd", txd, 1);
        check("mrst_empty", empty, 1);
        check("mrst_count0", count, 0);
        check("mrst_busy", tx_busy, 0);
        rst = 1'b0;
        wr_en = 1'b0;
        lows = 0;
        for (int k = 0; k < 4 * FRAME; k++) begin
            tick();
            if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("mrst_quiet", lows, 0);
        check("mrst_empty_after", empty, 1);

`ifdef UART_TX_PARITY_EN
        // even parity: 0x07 has three ones, 0x03 has two
        write_byte(8'h07);
        rx_frame(rb, rp);
        check("par_byte07", rb, 8'h07);
        check("par_bit07", rp, 1);
        wait_idle();
        write_byte(8'h03);
        rx_frame(rb, rp);
        check("par_byte03", rb, 8'h03);
        check("par_bit03", rp, 0);
        wait_idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
